// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard/debug control bundle: register numbers and control bits in,
// stall/flush/forward selects and debug status out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       RsD, RtD, RsE, RtE;
  logic [4:0]       WriteRegE, WriteRegM, WriteRegW;
  logic             RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW;
  logic             BranchD;
  logic             HaltReq, StepReq;

  logic             StallF, StallD, FlushE;
  logic             ForwardAD, ForwardBD;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             Halted;
  logic [CNT_W-1:0] StallCount;

  // master drives the pipeline/debug view, slave is the hazard unit
  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW,
           BranchD, HaltReq, StepReq,
    input  StallF, StallD, FlushE, ForwardAD, ForwardBD,
           ForwardAE, ForwardBE, Halted, StallCount
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW,
           BranchD, HaltReq, StepReq,
    output StallF, StallD, FlushE, ForwardAD, ForwardBD,
           ForwardAE, ForwardBE, Halted, StallCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS hazard unit: combinational forwarding and load/branch stall
// detection, plus a RUN/HALT/STEP debug FSM and a saturating stall counter.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input logic         CLK,
  input logic         RST,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    STEP = 2'd2
  } stateT;

  stateT            state, stateNext;
  logic             stepReqQ;
  logic             stepEdge;
  logic             lwStall, branchStall, hStall;
  logic             countEn;
  logic [CNT_W-1:0] stallCnt;

  // Execute-operand source: 2'b10 ALUOutM, 2'b01 ResultW, 2'b00 register file.
  function automatic logic [1:0] exeFwd(input logic [4:0] src,
                                        input logic       regWrM,
                                        input logic [4:0] wrM,
                                        input logic       regWrW,
                                        input logic [4:0] wrW);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != 5'd0 && regWrM && wrM == src)      sel = 2'b10;
    else if (src != 5'd0 && regWrW && wrW == src) sel = 2'b01;
    return sel;
  endfunction

  // A nonzero destination that matches either Decode source.
  function automatic logic hitsDecode(input logic [4:0] wr,
                                      input logic [4:0] rsD,
                                      input logic [4:0] rtD);
    return (wr != 5'd0) && (wr == rsD || wr == rtD);
  endfunction

  always_comb begin
    hz.ForwardAE = exeFwd(hz.RsE, hz.RegWriteM, hz.WriteRegM,
                          hz.RegWriteW, hz.WriteRegW);
    hz.ForwardBE = exeFwd(hz.RtE, hz.RegWriteM, hz.WriteRegM,
                          hz.RegWriteW, hz.WriteRegW);
    hz.ForwardAD = (hz.RsD != 5'd0) && hz.RegWriteM && (hz.WriteRegM == hz.RsD);
    hz.ForwardBD = (hz.RtD != 5'd0) && hz.RegWriteM && (hz.WriteRegM == hz.RtD);
  end

  always_comb begin
    lwStall     = hz.MemtoRegE && (hz.RtE != 5'd0) &&
                  (hz.RtE == hz.RsD || hz.RtE == hz.RtD);
    // beq compares in Decode, so an ALU result still in Execute or a load
    // result still in Memory cannot be forwarded in time
    branchStall = hz.BranchD &&
                  ((hz.RegWriteE && hitsDecode(hz.WriteRegE, hz.RsD, hz.RtD)) ||
                   (hz.MemtoRegM && hitsDecode(hz.WriteRegM, hz.RsD, hz.RtD)));
    hStall      = lwStall || branchStall;
  end

  // A held StepReq yields a single rising edge, hence a single STEP.
  assign stepEdge = hz.StepReq && !stepReqQ;

  // NOTE: every variable written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    stateNext = state;
    unique case (state)
      RUN:  if (hz.HaltReq) stateNext = HALT;
      HALT: begin
        if (!hz.HaltReq)   stateNext = RUN;
        else if (stepEdge) stateNext = STEP;
      end
      STEP: stateNext = hz.HaltReq ? HALT : RUN;
      default: stateNext = RUN;
    endcase
  end

  always_comb begin
    hz.StallF = hStall;
    hz.StallD = hStall;
    hz.FlushE = hStall;
    hz.Halted = 1'b0;
    if (!RST) begin
      // bubble Execute while the rest of the pipe restarts from fetch
      hz.StallF = 1'b0;
      hz.StallD = 1'b0;
      hz.FlushE = 1'b1;
    end else if (state == HALT) begin
      // Decode is frozen so its instruction survives; Execute sees bubbles
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.FlushE = 1'b1;
      hz.Halted = 1'b1;
    end
  end

  assign countEn       = (state == RUN || state == STEP) && hStall;
  assign hz.StallCount = stallCnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= RUN;
      stepReqQ <= 1'b0;
      stallCnt <= '0;
    end else begin
      state    <= stateNext;
      stepReqQ <= hz.StepReq;
      if (countEn && stallCnt != {CNT_W{1'b1}})
        stallCnt <= stallCnt + 1'b1;
    end
  end

  // STEP is a one-cycle state by construction.
  stepOneCycle: assert property (@(posedge CLK) disable iff (!RST)
    state == STEP |=> state != STEP);

endmodule
